// File: rtl/cache_pkg.sv
// Shared state encoding, default-geometry widths and address-field helpers
// for the direct-mapped write-through data cache.
package cache_pkg;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

    localparam int ADDR_W_DFLT     = 32;
    localparam int LINE_WORDS_DFLT = 4;
    localparam int NUM_LINES_DFLT  = 16;

    localparam int OFFSET_W = $clog2(LINE_WORDS_DFLT);
    localparam int INDEX_W  = $clog2(NUM_LINES_DFLT);
    localparam int TAG_W    = ADDR_W_DFLT - INDEX_W - OFFSET_W - 2;

    // Generic bit-field extraction; callers size-cast the result to the field width.
    function automatic logic [63:0] addr_field(input logic [63:0] addr, input int lsb,
                                               input int width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return (addr >> lsb) & mask;
    endfunction

    function automatic logic [63:0] word_offset(input logic [63:0] addr, input int offset_w);
        return addr_field(addr, 2, offset_w);
    endfunction

    function automatic logic [63:0] line_index(input logic [63:0] addr, input int offset_w,
                                               input int index_w);
        return addr_field(addr, 2 + offset_w, index_w);
    endfunction

    function automatic logic [63:0] line_tag(input logic [63:0] addr, input int offset_w,
                                             input int index_w, input int tag_w);
        return addr_field(addr, 2 + offset_w + index_w, tag_w);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid bits, tag RAM and data RAM for the direct-mapped cache.
// Reads are asynchronous; word, tag and valid updates happen on the clock edge.
module dcache_array #(
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16,
    parameter int OFFSET_W   = 2,
    parameter int INDEX_W    = 4,
    parameter int TAG_W      = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                word_we,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                tag_we,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic                inval
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_ram  [NUM_LINES];
    logic [DATA_W-1:0]    data_ram [NUM_LINES][LINE_WORDS];

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_ram[rd_index];
    assign rd_data  = data_ram[rd_index][rd_offset];

    // Reset wins so an aborted refill can never leave its line marked valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[wr_index] <= 1'b1;
        end else if (inval) begin
            valid[wr_index] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_ram[wr_index] <= wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (word_we) begin
            data_ram[wr_index][wr_offset] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller:
// zero-cycle load hits, full-line refill on a load miss, stall on every store.
module dcache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              Stall,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       HitCount,
    output logic [31:0]       MissCount
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TG_W  = ADDR_W - IDX_W - OFF_W - 2;

    state_t            state;
    logic [TG_W-1:0]   lat_tag;
    logic [IDX_W-1:0]  lat_index;
    logic [OFF_W-1:0]  cnt;

    logic [OFF_W-1:0]  cur_offset;
    logic [IDX_W-1:0]  cur_index;
    logic [TG_W-1:0]   cur_tag;
    logic              rd_valid;
    logic [TG_W-1:0]   rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              hit;
    logic              load_req;
    logic              last_word;

    logic              word_we;
    logic              tag_we;
    logic              inval;
    logic [IDX_W-1:0]  wr_index;
    logic [OFF_W-1:0]  wr_offset;
    logic [DATA_W-1:0] wr_data;

    assign cur_offset = OFF_W'(word_offset(64'(Addr), OFF_W));
    assign cur_index  = IDX_W'(line_index(64'(Addr), OFF_W, IDX_W));
    assign cur_tag    = TG_W'(line_tag(64'(Addr), OFF_W, IDX_W, TG_W));

    assign hit       = rd_valid && (rd_tag == cur_tag);
    assign load_req  = MemRead && !MemWrite;
    assign last_word = (cnt == OFF_W'(LINE_WORDS - 1));

    dcache_array #(
        .DATA_W    (DATA_W),
        .LINE_WORDS(LINE_WORDS),
        .NUM_LINES (NUM_LINES),
        .OFFSET_W  (OFF_W),
        .INDEX_W   (IDX_W),
        .TAG_W     (TG_W)
    ) u_array (
        .clk      (CLK),
        .rst      (RST),
        .rd_index (cur_index),
        .rd_offset(cur_offset),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .word_we  (word_we),
        .wr_index (wr_index),
        .wr_offset(wr_offset),
        .wr_data  (wr_data),
        .tag_we   (tag_we),
        .wr_tag   (lat_tag),
        .inval    (inval)
    );

    // Refill writes target the latched line; store-hit updates target the live address.
    always_comb begin
        word_we   = 1'b0;
        tag_we    = 1'b0;
        inval     = 1'b0;
        wr_index  = cur_index;
        wr_offset = cur_offset;
        wr_data   = WriteData;
        case (state)
            IDLE: begin
                inval = load_req && !hit;
            end
            REFILL: begin
                wr_index  = lat_index;
                wr_offset = cnt;
                wr_data   = mem_rdata;
                word_we   = mem_ack && !RST;
                tag_we    = mem_ack && last_word && !RST;
            end
            WRITE: begin
                word_we = mem_ack && hit && !RST;
            end
            default: ;
        endcase
    end

    always_comb begin
        Stall     = 1'b0;
        ReadData  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                Stall = MemWrite || (MemRead && !hit);
                if (load_req && hit) begin
                    ReadData = rd_data;
                end
            end
            REFILL: begin
                Stall    = 1'b1;
                mem_addr = {lat_tag, lat_index, cnt, 2'b00};
            end
            WRITE: begin
                Stall     = 1'b1;
                mem_addr  = {Addr[ADDR_W-1:2], 2'b00};
                mem_wdata = WriteData;
            end
            default: ;
        endcase
    end

    assign mem_rd_req = (state == REFILL);
    assign mem_wr_req = (state == WRITE);

    // An ack seen in IDLE or WDONE falls through every branch below and is dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            HitCount  <= '0;
            MissCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MemWrite) begin
                        state <= WRITE;
                    end else if (MemRead) begin
                        if (hit) begin
                            HitCount <= HitCount + 32'd1;
                        end else begin
                            MissCount <= MissCount + 32'd1;
                            lat_tag   <= cur_tag;
                            lat_index <= cur_index;
                            cnt       <= '0;
                            state     <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        cnt <= cnt + 1'b1;
                        if (last_word) begin
                            state <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state <= WDONE;
                    end
                end
                WDONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed vector table, reset-mid-refill sequence and
// random loads/stores against a line-level cache model and a latency-controlled memory.
module tb_dcache_ctrl;

    localparam int LW = 4;

    logic        CLK;
    logic        RST;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] HitCount;
    logic [31:0] MissCount;

    dcache_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .mem_rd_req(mem_rd_req),
        .mem_wr_req(mem_wr_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .HitCount  (HitCount),
        .MissCount (MissCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    // Memory environment
    logic [31:0] mem [int unsigned];
    logic [31:0] rd_log [$];
    int          lat = 0;
    int          wcnt = 0;
    int          ack_cnt = 0;

    // Cache model: which tag each line holds
    bit          m_valid [16];
    logic [23:0] m_tag   [16];

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        bit          hit;
        logic [31:0] data;
    } vec_t;

    vec_t vt [14];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge CLK);
            #2;
            if (mem_rd_req || mem_wr_req) begin
                if (wcnt >= lat) begin
                    mem_ack = 1'b1;
                    wcnt    = 0;
                    ack_cnt++;
                    if (mem_rd_req) begin
                        mem_rdata = mem_rd(mem_addr);
                        rd_log.push_back(mem_addr);
                    end else begin
                        mem[mem_addr] = mem_wdata;
                    end
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = '0;
                wcnt      = 0;
            end
        end
    end

    task automatic do_op(input bit is_wr, input bit is_rd, input logic [31:0] a,
                         input logic [31:0] wd, input int l, input bit exp_hit,
                         input logic [31:0] exp_data);
        int          stall_n;
        int          wr_n;
        bit          stable_ok;
        bit          done;
        logic [31:0] base;
        base      = {a[31:4], 4'b0000};
        stall_n   = 0;
        wr_n      = 0;
        stable_ok = 1'b1;
        done      = 1'b0;
        @(posedge CLK);
        #1;
        lat = l;
        rd_log.delete();
        MemWrite  = is_wr;
        MemRead   = is_rd;
        Addr      = a;
        WriteData = wd;
        for (int c = 0; c <= 200; c++) begin
            @(negedge CLK);
            if (!Stall) begin
                done = 1'b1;
                break;
            end
            if (mem_wr_req) begin
                wr_n++;
                if (mem_addr !== {a[31:2], 2'b00} || mem_wdata !== wd) stable_ok = 1'b0;
            end
            stall_n++;
        end
        check("stall_release", 32'(done), 32'd1);
        if (is_wr) begin
            check("store_stall_cycles", 32'(stall_n), 32'(2 + l));
            check("wr_req_cycles", 32'(wr_n), 32'(l + 1));
            check("wr_req_stable", 32'(stable_ok), 32'd1);
            check("mem_written", mem_rd(a), wd);
        end else begin
            check("load_data", ReadData, exp_data);
            check("load_stall_cycles", 32'(stall_n), exp_hit ? 32'd0 : 32'(1 + LW * (l + 1)));
            if (!exp_hit) begin
                check("refill_beats", 32'(rd_log.size()), 32'(LW));
                for (int i = 0; i < rd_log.size() && i < LW; i++)
                    check("refill_addr", rd_log[i], base + 32'(4 * i));
                exp_miss++;
            end
            exp_hits++;
            m_valid[a[7:4]] = 1'b1;
            m_tag[a[7:4]]   = a[31:8];
        end
        @(posedge CLK);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge CLK);
        check("idle_stall", 32'(Stall), 32'd0);
        check("idle_rd_req", 32'(mem_rd_req), 32'd0);
        check("idle_wr_req", 32'(mem_wr_req), 32'd0);
        check("idle_readdata", ReadData, 32'd0);
        check("hit_count", HitCount, 32'(exp_hits));
        check("miss_count", MissCount, 32'(exp_miss));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          got;
        int          base_ack;
        logic [31:0] a;
        logic [31:0] wd;
        bit          wr;
        bit          rd;
        int          l;
        bit          eh;

        mem[32'h40] = 32'hA0;
        mem[32'h44] = 32'hA1;
        mem[32'h48] = 32'hA2;
        mem[32'h4C] = 32'hA3;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;

        vt[0]  = '{0, 1, 32'h40,   32'h0,        0, 0, 32'hA0};
        vt[1]  = '{0, 1, 32'h48,   32'h0,        0, 1, 32'hA2};
        vt[2]  = '{1, 0, 32'h44,   32'hDEADBEEF, 2, 0, 32'h0};
        vt[3]  = '{0, 1, 32'h44,   32'h0,        0, 1, 32'hDEADBEEF};
        vt[4]  = '{1, 1, 32'h48,   32'h55AA55AA, 0, 0, 32'h0};
        vt[5]  = '{0, 1, 32'h48,   32'h0,        1, 1, 32'h55AA55AA};
        vt[6]  = '{1, 0, 32'h1000, 32'h12345678, 1, 0, 32'h0};
        vt[7]  = '{0, 1, 32'h1000, 32'h0,        0, 0, 32'h12345678};
        vt[8]  = '{0, 1, 32'h440,  32'h0,        1, 0, 32'hC0DE0440};
        vt[9]  = '{0, 1, 32'h40,   32'h0,        0, 0, 32'hA0};
        vt[10] = '{0, 1, 32'h440,  32'h0,        3, 0, 32'hC0DE0440};
        vt[11] = '{0, 1, 32'h40,   32'h0,        0, 0, 32'hA0};
        vt[12] = '{0, 1, 32'h4C,   32'h0,        2, 1, 32'hA3};
        vt[13] = '{0, 1, 32'h44,   32'h0,        0, 1, 32'hDEADBEEF};

        RST = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_rd_req", 32'(mem_rd_req), 32'd0);
        check("rst_wr_req", 32'(mem_wr_req), 32'd0);
        check("rst_readdata", ReadData, 32'd0);
        check("rst_hit_count", HitCount, 32'd0);
        check("rst_miss_count", MissCount, 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;

        for (int i = 0; i < 14; i++)
            do_op(vt[i].wr, vt[i].rd, vt[i].addr, vt[i].wdata, vt[i].lat, vt[i].hit, vt[i].data);

        // Reset after the second refill ack of a miss to 0x840
        @(posedge CLK);
        #1;
        lat      = 0;
        base_ack = ack_cnt;
        MemRead  = 1'b1;
        Addr     = 32'h840;
        got      = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge CLK);
            if (ack_cnt >= base_ack + 2) begin
                got = 1'b1;
                break;
            end
        end
        check("rst_refill_wait", 32'(got), 32'd1);
        #1;
        RST     = 1'b1;
        MemRead = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("abort_rd_req", 32'(mem_rd_req), 32'd0);
        check("abort_stall", 32'(Stall), 32'd0);
        check("abort_hit_count", HitCount, 32'd0);
        check("abort_miss_count", MissCount, 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        exp_hits = 0;
        exp_miss = 0;
        do_op(0, 1, 32'h840, 32'h0, 0, 0, mem_rd(32'h840));
        do_op(0, 1, 32'h40,  32'h0, 1, 0, 32'hA0);

        for (int n = 0; n < 60; n++) begin
            a  = {20'h0, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 2'b00};
            wr = ($urandom_range(0, 9) < 3);
            rd = !wr || ($urandom_range(0, 3) == 0);
            l  = $urandom_range(0, 3);
            wd = $urandom;
            eh = m_valid[a[7:4]] && (m_tag[a[7:4]] == a[31:8]);
            do_op(wr, rd, a, wd, l, eh, mem_rd(a));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache placed between the DataBus load/store port and main memory. Serves word loads in zero extra cycles on a hit. Stalls the core on a read miss while it refills a full line over a req/ack memory handshake. Stalls on every store until memory acknowledges the write.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, word width (fixed at 32)
- LINE_WORDS, 4, words per line (power of 2)
- NUM_LINES, 16, number of lines (power of 2)

Ports:
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- MemRead  in  1  core load request, held while Stall=1
- MemWrite  in  1  core store request, held while Stall=1
- Addr  in  ADDR_W  core byte address; bits [1:0] ignored
- WriteData  in  DATA_W  store data
- ReadData  out  DATA_W  load data, valid when MemRead=1 and Stall=0
- Stall  out  1  freeze core PC/pipeline
- mem_rd_req  out  1  memory read request
- mem_wr_req  out  1  memory write request
- mem_addr  out  ADDR_W  word-aligned memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion strobe from memory
- HitCount  out  32  loads that hit
- MissCount  out  32  loads that missed

## Operation
- Address split: word offset = Addr[log2(LINE_WORDS)+1:2]; index = next log2(NUM_LINES) bits; tag = remaining upper bits (24 bits at defaults).
- Hit = valid[index] and tag_array[index] == tag.
- If MemRead and MemWrite are both high, MemWrite has priority and the read is ignored.
- FSM states: IDLE, REFILL, WRITE, WDONE.
- IDLE, MemWrite=1:
  - Stall=1 combinationally.
  - Next state WRITE.
- IDLE, MemRead=1, hit:
  - ReadData = cached word combinationally; Stall=0.
  - HitCount increments.
- IDLE, MemRead=1, miss:
  - Stall=1 combinationally.
  - MissCount increments.
  - Latch tag and index; word counter cleared; next state REFILL.
- REFILL:
  - mem_rd_req=1; mem_addr = {latched tag, latched index, counter, 2'b00}; Stall=1.
  - On mem_ack, write mem_rdata into the line at the counter position and increment the counter.
  - On the ack for the last word: set the valid bit, write the tag, go to IDLE.
  - The held load then hits in IDLE. That hit is counted in HitCount.
- WRITE:
  - mem_wr_req=1; mem_addr = {Addr[ADDR_W-1:2], 2'b00}; mem_wdata = WriteData; Stall=1.
  - On mem_ack: if the address hits, update that cached word; go to WDONE.
  - On a miss, no allocation.
- WDONE:
  - Stall=0 for one cycle; the request is ignored, since the core retires the store on this edge.
  - Next state IDLE.
- The memory request stays asserted with a stable address and data until mem_ack. Memory may take any number of cycles.
- No request in IDLE: Stall=0, no memory request, counters hold.
- Counters wrap modulo 2^32.

## Timing
- Reset values:
  - state IDLE; all valid bits 0.
  - HitCount and MissCount 0.
  - mem_rd_req=0, mem_wr_req=0; Stall=0; ReadData 0 when idle.
  - Data and tag arrays are not cleared.
- Read hit: 0 added cycles.
- Read miss: Stall high from the request cycle through the last-ack cycle, then 1 hit cycle. With zero-wait memory (ack in the first REFILL cycle), the load completes in 1+LINE_WORDS+1 cycles.
- Store: Stall high in IDLE and all WRITE cycles, low in WDONE. With zero-wait memory this is 3 cycles total.
- Reset mid-REFILL: abort; the line stays invalid; request deasserts in the cycle after RST is sampled; a late mem_ack is ignored.
- Reset mid-WRITE: abort; memory may already have completed the write, and the cache is not updated.
- A mem_ack received in IDLE or WDONE is ignored.
- The refill counter wraps only at line completion, never mid-line.

## Structure
- Package cache_pkg:
  - state enum {IDLE, REFILL, WRITE, WDONE}
  - derived widths: OFFSET_W, INDEX_W, TAG_W
  - address field extraction functions
- Sub-module dcache_array:
  - valid bits, tag RAM and data RAM
  - asynchronous read; synchronous word write and tag/valid write; synchronous valid-clear on RST
- The FSM, counters and memory handshake stay in dcache_ctrl.

## Test plan
- Cold load:
  - After reset, MemRead at Addr=0x0000_0040 with memory returning 0xA0,0xA1,0xA2,0xA3 at 0x40..0x4C.
  - Required: four rd_req beats at those addresses; Stall drops; ReadData=0xA0; MissCount=1, HitCount=1.
- Same-line hit:
  - Load 0x0000_0048 next.
  - Required: Stall=0 that cycle; ReadData=0xA2; no mem_rd_req; HitCount=2.
- Store hit with 3-cycle memory latency:
  - Store 0xDEADBEEF to 0x44.
  - Required: mem_wr_req held 3 cycles with the same address and data; WDONE Stall=0; a following load of 0x44 hits with 0xDEADBEEF.
- Store miss:
  - Store to 0x0000_1000.
  - Required: memory written; a following load of 0x1000 misses and refills (MissCount increments), so no allocation occurred.
- Conflict eviction:
  - Load 0x40, then 0x440 (same index, different tag), then 0x40.
  - Required: three misses.
- Reset mid-refill:
  - Assert RST after the second ack.
  - Required: next cycle rd_req=0 and Stall=0; counters 0; reloading 0x40 misses and refills again.
